// File: rtl/case_5_mul_arb_pkg.sv
// Shared constants and pipeline stage types for the arbitrated multiplier.
// S1 carries the operands of the accepted request; S2 carries the result.
package case_5_mul_arb_pkg;

  localparam int NUM_REQ    = 4;
  localparam int DIN0_WIDTH = 10;
  localparam int DIN1_WIDTH = 8;
  localparam int DOUT_WIDTH = 10;
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic                         valid;
    logic signed [DIN0_WIDTH-1:0] din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic [ID_WIDTH-1:0]          id;
  } s1_stage_t;

  typedef struct packed {
    logic                  valid;
    logic [DOUT_WIDTH-1:0] dout;
    logic [ID_WIDTH-1:0]   id;
  } s2_stage_t;

endpackage

// File: rtl/case_5_mul_10s_8s_10_1_1.sv
// Combinational signed multiplier returning the low dout_WIDTH bits of the
// full product (two's-complement wrap).
module case_5_mul_10s_8s_10_1_1 #(
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 10
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  // The low n bits of a product depend only on the low n bits of the
  // sign-extended operands, so multiplying at the result width is exact.
  logic signed [dout_WIDTH-1:0] a_ext;
  logic signed [dout_WIDTH-1:0] b_ext;

  assign a_ext = dout_WIDTH'($signed(din0));
  assign b_ext = dout_WIDTH'($signed(din1));
  assign dout  = a_ext * b_ext;

endmodule

// File: rtl/case_5_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner only when advance is pulsed.
module case_5_rr_arbiter
  import case_5_mul_arb_pkg::*;
#(
  parameter int N = NUM_REQ
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] gnt_idx;
  logic          found;

  // First pass covers indices from the pointer upward, second pass wraps.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IW'(i) >= ptr_q)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gnt_idx  = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IW'(i) < ptr_q)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gnt_idx  = IW'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/case_5_mul_arbiter.sv
// Shares one signed multiplier among NUM_REQ requesters: round-robin grant,
// operand stage S1, multiply, result stage S2 driving the response port.
module case_5_mul_arbiter
  import case_5_mul_arb_pkg::*;
#(
  parameter int NUM_REQ    = case_5_mul_arb_pkg::NUM_REQ,
  parameter int DIN0_WIDTH = case_5_mul_arb_pkg::DIN0_WIDTH,
  parameter int DIN1_WIDTH = case_5_mul_arb_pkg::DIN1_WIDTH,
  parameter int DOUT_WIDTH = case_5_mul_arb_pkg::DOUT_WIDTH
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DOUT_WIDTH-1:0]         rsp_dout,
  output logic [ID_WIDTH-1:0]           rsp_id
);

  s1_stage_t s1_q;
  s1_stage_t s1_d;
  s2_stage_t s2_q;
  s2_stage_t s2_d;

  logic                         s1_load;
  logic                         s2_load;
  logic                         accept;
  logic [NUM_REQ-1:0]           grant;
  logic [DOUT_WIDTH-1:0]        mul_dout;
  logic signed [DIN0_WIDTH-1:0] sel_din0;
  logic signed [DIN1_WIDTH-1:0] sel_din1;
  logic [ID_WIDTH-1:0]          sel_id;

  assign s2_load = !s2_q.valid || rsp_ready;
  assign s1_load = !s1_q.valid || s2_load;

  // Grant is already qualified by req_valid, so any ready bit is a transfer.
  assign req_ready = (ap_rst_n && s1_load) ? grant : '0;
  assign accept    = |req_ready;

  case_5_rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    sel_din0 = '0;
    sel_din1 = '0;
    sel_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_din0 = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
        sel_din1 = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
        sel_id   = ID_WIDTH'(i);
      end
    end
  end

  case_5_mul_10s_8s_10_1_1 #(
    .din0_WIDTH (DIN0_WIDTH),
    .din1_WIDTH (DIN1_WIDTH),
    .dout_WIDTH (DOUT_WIDTH)
  ) u_mul (
    .din0 (s1_q.din0),
    .din1 (s1_q.din1),
    .dout (mul_dout)
  );

  // Payload only updates on real data so a stalled S2 keeps its outputs.
  always_comb begin
    s1_d = s1_q;
    if (s1_load) begin
      s1_d.valid = accept;
      if (accept) begin
        s1_d.din0 = sel_din0;
        s1_d.din1 = sel_din1;
        s1_d.id   = sel_id;
      end
    end
    s2_d = s2_q;
    if (s2_load) begin
      s2_d.valid = s1_q.valid;
      if (s1_q.valid) begin
        s2_d.dout = mul_dout;
        s2_d.id   = s1_q.id;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign rsp_valid = s2_q.valid;
  assign rsp_dout  = s2_q.dout;
  assign rsp_id    = s2_q.id;

endmodule

// File: tb/tb_case_5_mul_arbiter.sv
// Scoreboard bench for case_5_mul_arbiter: directed scenarios followed by a
// randomized phase, checked against a round-robin / depth-2 pipeline model.
`timescale 1ns/1ps
module tb_case_5_mul_arbiter;

  localparam int N  = 4;
  localparam int W0 = 10;
  localparam int W1 = 8;
  localparam int WO = 10;
  localparam int IW = 2;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*W0-1:0] req_din0 = '0;
  logic [N*W1-1:0] req_din1 = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [WO-1:0]   rsp_dout;
  logic [IW-1:0]   rsp_id;

  always #5 ap_clk = ~ap_clk;

  case_5_mul_arbiter dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dout  (rsp_dout),
    .rsp_id    (rsp_id)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            id;
    logic [WO-1:0] dout;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          m_e;
  int            occ = 0;
  int            last_gnt = N - 1;
  int            cyc = 0;
  int            last_bp = 0;
  int            n_acc = 0;
  int            n_rsp = 0;
  int            m_win;
  int            m_idx;
  int            m_a;
  int            m_b;
  logic          m_can;
  logic [N-1:0]  m_exp;
  logic [N-1:0]  acc_mask = '0;
  logic          stall_prev = 1'b0;
  logic [WO-1:0] prev_dout = '0;
  logic [IW-1:0] prev_id = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WO-1:0] model_mul(input int a, input int b);
    int p;
    p = a * b;
    return p[WO-1:0];
  endfunction

  // Monitor: model the grant, track occupancy, score responses.
  always @(negedge ap_clk) begin
    cyc++;
    if (!ap_rst_n) begin
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
      sb.delete();
      occ        = 0;
      last_gnt   = N - 1;
      stall_prev = 1'b0;
      acc_mask   = '0;
      n_acc      = 0;
      n_rsp      = 0;
    end else begin
      if (!rsp_ready) last_bp = cyc;
      m_win = -1;
      for (int k = 1; k <= N; k++) begin
        m_idx = (last_gnt + k) % N;
        if (m_win < 0 && req_valid[m_idx]) m_win = m_idx;
      end
      m_can = (m_win >= 0) && (occ < 2 || rsp_ready);
      m_exp = m_can ? N'(1 << m_win) : '0;
      chk("req_ready", {28'd0, req_ready}, {28'd0, m_exp});
      acc_mask = req_valid & req_ready;
      if (stall_prev) begin
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_dout", {22'd0, rsp_dout}, {22'd0, prev_dout});
        chk("hold_id", {30'd0, rsp_id}, {30'd0, prev_id});
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id %0d dout %0h, expected no response", rsp_id, rsp_dout);
        end else begin
          m_e = sb.pop_front();
          chk("rsp_dout", {22'd0, rsp_dout}, {22'd0, m_e.dout});
          chk("rsp_id", {30'd0, rsp_id}, m_e.id);
          if (last_bp < m_e.cyc) chk("latency", cyc - m_e.cyc, 32'd2);
          $display("rsp id=%0d dout=%03h latency=%0d", rsp_id, rsp_dout, cyc - m_e.cyc);
          occ--;
          n_rsp++;
        end
      end
      if (m_can) begin
        m_a = $signed(req_din0[m_win*W0 +: W0]);
        m_b = $signed(req_din1[m_win*W1 +: W1]);
        sb.push_back('{id: m_win, dout: model_mul(m_a, m_b), cyc: cyc});
        last_gnt = m_win;
        occ++;
        n_acc++;
      end
      stall_prev = rsp_valid && !rsp_ready;
      prev_dout  = rsp_dout;
      prev_id    = rsp_id;
    end
  end

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases
  // between edges so the caller drives cycle 0 immediately.
  task automatic do_reset();
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_rst_rsp_dout", {22'd0, rsp_dout}, 32'd0);
    chk("async_rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("async_rst_req_ready", {28'd0, req_ready}, 32'd0);
    req_valid = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic set_op(input int p, input int a, input int b);
    req_din0[p*W0 +: W0] = W0'(a);
    req_din1[p*W1 +: W1] = W1'(b);
  endtask

  function automatic int pick_a();
    case ($urandom_range(0, 9))
      0: return 511;
      1: return -512;
      default: return int'($urandom_range(0, 1023)) - 512;
    endcase
  endfunction

  function automatic int pick_b();
    case ($urandom_range(0, 9))
      0: return 127;
      1: return -128;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic refill_accepted();
    for (int p = 0; p < N; p++)
      if (acc_mask[p]) set_op(p, pick_a(), pick_b());
  endtask

  task automatic drain(input string name);
    int n;
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      next_cycle();
      n++;
    end
    @(negedge ap_clk);
    chk({name, "_empty"}, sb.size(), 32'd0);
    chk({name, "_count"}, n_rsp, n_acc);
  endtask

  int acc_cnt;
  int vp;
  int rp;

  initial begin
    // Single request on port 2: -3 * 5
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    set_op(2, -3, 5);
    @(negedge ap_clk);
    chk("t_single_ready", {28'd0, req_ready}, 32'h4);
    next_cycle();
    req_valid = '0;
    @(negedge ap_clk);
    chk("t_single_c1_valid", {31'd0, rsp_valid}, 32'd0);
    next_cycle();
    @(negedge ap_clk);
    chk("t_single_c2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t_single_dout", {22'd0, rsp_dout}, 32'h3F1);
    chk("t_single_id", {30'd0, rsp_id}, 32'd2);

    // All four requesting from reset
    do_reset();
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int p = 0; p < N; p++) set_op(p, 10 * p + 3, -(p + 2));
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        next_cycle();
        req_valid &= ~acc_mask;
      end
      @(negedge ap_clk);
      if (c < 4) chk("t_all4_ready", {28'd0, req_ready}, 1 << c);
      if (c >= 2) begin
        chk("t_all4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t_all4_rsp_id", {30'd0, rsp_id}, c - 2);
      end
    end
    drain("t_all4");

    // Overflow wrap: 511*127 and -512*127
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1001;
    set_op(0, 511, 127);
    set_op(3, -512, 127);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        next_cycle();
        req_valid &= ~acc_mask;
      end
      @(negedge ap_clk);
      if (c == 2) begin
        chk("t_ovf_id0", {30'd0, rsp_id}, 32'd0);
        chk("t_ovf_dout0", {22'd0, rsp_dout}, 32'h181);
      end
      if (c == 3) begin
        chk("t_ovf_id3", {30'd0, rsp_id}, 32'd3);
        chk("t_ovf_dout3", {22'd0, rsp_dout}, 32'h200);
      end
    end
    drain("t_ovf");

    // Backpressure with continuous requests
    do_reset();
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int p = 0; p < N; p++) set_op(p, pick_a(), pick_b());
    acc_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        next_cycle();
        refill_accepted();
      end
      @(negedge ap_clk);
      acc_cnt += $countones(req_valid & req_ready);
    end
    chk("t_bp_accepts", acc_cnt, 32'd2);
    next_cycle();
    refill_accepted();
    rsp_ready = 1'b1;
    repeat (10) begin
      next_cycle();
      refill_accepted();
    end
    drain("t_bp");

    // Reset with both stages full; pointer must restart at 0
    do_reset();
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int p = 0; p < N; p++) set_op(p, pick_a(), pick_b());
    repeat (3) begin
      next_cycle();
      refill_accepted();
    end
    @(negedge ap_clk);
    chk("t_rst_pre_valid", {31'd0, rsp_valid}, 32'd1);
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    set_op(1, 7, -9);
    set_op(3, 1, 1);
    @(negedge ap_clk);
    chk("t_rst_first_grant", {28'd0, req_ready}, 32'h2);
    next_cycle();
    req_valid = '0;
    drain("t_rst");

    // Randomized traffic with dropped requests and varying backpressure
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      vp = (ph == 0) ? 90 : (ph == 1) ? 30 : (ph == 2) ? 100 : 60;
      rp = (ph == 0) ? 100 : (ph == 1) ? 50 : (ph == 2) ? 20 : 85;
      for (int c = 0; c < 700; c++) begin
        for (int p = 0; p < N; p++) begin
          if (req_valid[p] && !acc_mask[p]) begin
            if ($urandom_range(0, 99) < 5) req_valid[p] = 1'b0;
          end else begin
            req_valid[p] = ($urandom_range(0, 99) < vp);
            set_op(p, pick_a(), pick_b());
          end
        end
        rsp_ready = ($urandom_range(0, 99) < rp);
        next_cycle();
      end
    end
    drain("t_rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/case_5_mul_arbiter.md
CASE_5_MUL_ARBITER -- requirements
Module: case_5_mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the multiplier.
REQ-002 Parameter DIN0_WIDTH, default 10: signed operand A width.
REQ-003 Parameter DIN1_WIDTH, default 8: signed operand B width.
REQ-004 Parameter DOUT_WIDTH, default 10: result width; truncated product.
REQ-005 ap_clk  in  1  single clock; all state on rising edge.
REQ-006 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-008 req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-009 req_din0  in  NUM_REQ*DIN0_WIDTH  packed operand A; requester i in slice i.
REQ-010 req_din1  in  NUM_REQ*DIN1_WIDTH  packed operand B; requester i in slice i.
REQ-011 rsp_valid  out  1  result valid.
REQ-012 rsp_ready  in  1  downstream accept.
REQ-013 rsp_dout  out  DOUT_WIDTH  product result.
REQ-014 rsp_id  out  clog2(NUM_REQ)  index of the requester that owns rsp_dout.

Function
REQ-015 A transfer on port i SHALL occur when req_valid[i] and req_ready[i] are both high on a rising edge; a response transfer SHALL occur when rsp_valid and rsp_ready are both high.
REQ-016 Arbitration SHALL be round-robin. Priority starts at the index after the last granted requester and wraps NUM_REQ-1 -> 0.
REQ-017 The round-robin pointer SHALL advance only on an accepted transfer, never on a grant alone.
REQ-018 Pipeline, two register stages:
  - S1 holds operands plus ID.
  - S2 holds the result plus ID and drives the rsp_* outputs.
  - An accepted request in cycle N SHALL appear as rsp_valid in cycle N+2 when there is no backpressure.
REQ-019 S2 SHALL load when it is empty or its response transfer occurs in the same cycle. S1 SHALL load when it is empty or it is advancing into S2.
REQ-020 req_ready SHALL be high only for the granted requester, and only when S1 can load that cycle. req_ready is combinational from req_valid and pipeline state.
REQ-021 Arithmetic SHALL be a full signed product of 18 bits, with rsp_dout = low DOUT_WIDTH bits (two's-complement wrap, no saturation).
REQ-022 While rsp_valid is high and rsp_ready is low, rsp_dout and rsp_id SHALL hold stable.
REQ-023 Throughput SHALL be one result per cycle when rsp_ready is held high and requests are continuous.
REQ-024 When all req_valid bits are low, no req_ready bit SHALL be high, and the pointer SHALL hold.
REQ-025 A requester that drops req_valid before acceptance SHALL lose its grant without penalty, and the pointer SHALL be unchanged.

Reset
REQ-026 While ap_rst_n is low:
  - rsp_valid = 0, rsp_dout = 0, rsp_id = 0, S1 valid = 0.
  - All req_ready bits = 0.
  - Pointer = 0, so requester 0 has highest priority.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operations immediately, with no response emitted afterwards.
REQ-028 The first acceptance SHALL be possible on the first rising edge after ap_rst_n deasserts.

Structure
REQ-029 Package case_5_mul_arb_pkg SHALL hold:
  - NUM_REQ, DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH and ID_WIDTH constants.
  - The S1 and S2 stage struct typedefs (valid, operands or result, id).
REQ-030 The multiplier SHALL be a single instance of the existing combinational case_5_mul_10s_8s_10_1_1 unit, placed between S1 and S2. It is the only multiplier in the block.
REQ-031 The round-robin arbiter SHALL be a sub-module, case_5_rr_arbiter, with inputs req and advance and output one-hot grant.

Verification
REQ-032 Single request, rsp_ready = 1, port 2, din0 = -3 (10'h3FD), din1 = 5: req_ready[2] high in cycle 0 -> rsp_valid in cycle 2, rsp_dout = 10'h3F1, rsp_id = 2.
REQ-033 All four req_valid high from reset, each holding a distinct operand pair until accepted, rsp_ready = 1: accepts in order 0, 1, 2, 3 -> responses in cycles 2-5 with rsp_id 0, 1, 2, 3.
REQ-034 Overflow on port 0, din0 = 511, din1 = 127: rsp_dout = 10'h181 (64897 mod 1024).
REQ-035 Backpressure: rsp_ready = 0 for 5 cycles with continuous requests -> at most 2 accepts, rsp_dout/rsp_id stable throughout, no loss or duplication after rsp_ready returns to 1.
REQ-036 Reset mid-operation: pulse ap_rst_n low with S1 and S2 both valid -> rsp_valid = 0 in the same cycle, pointer back to 0, and the next accept goes to the lowest-index valid requester.
